// File: rtl/frame_buffer_pkg.sv
// Shared frame-buffer definitions: controller state encoding and the
// supported read-latency range, used by both read and write controllers.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    WAIT_PAGE  = 2'd0,
    WAIT_VSYNC = 2'd1,
    ACTIVE     = 2'd2
  } fb_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

  // Out-of-range latencies are pinned to the nearest supported value.
  function automatic int clamp_rd_latency(input int lat);
    if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
    if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline with synchronous clear of every stage.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign data_o = stage[DEPTH-1];

endmodule

// File: rtl/frame_buffer_read_ctrl.sv
// Frame-buffer read side: walks a linear pixel pointer in step with display
// enable and realigns HDMI timing with the returned pixel data.
//
// state      | meaning
// WAIT_PAGE  | no complete frame written yet; no reads
// WAIT_VSYNC | frame available, waiting for a vsync rising edge to start
// ACTIVE     | reading one pixel per de_i cycle, pointer wraps at frame end
module frame_buffer_read_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    RD_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] BLANK_PIXEL = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  page_written_once_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_o,
  output logic [ADDR_WIDTH-1:0] addr_rd_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  frame_misalign_o
);

  localparam int LAT = clamp_rd_latency(RD_LATENCY);

  fb_state_e             state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next, total_pixel;
  logic [31:0]           pixel_count;
  logic                  vsync_prev, vsync_rise, pixel_valid;
  logic [3:0]            dly_in, dly_out;

  assign pixel_count = {16'd0, resolution_width_i} * {16'd0, resolution_depth_i};
  assign total_pixel = ADDR_WIDTH'(pixel_count) - ADDR_WIDTH'(1);
  assign vsync_rise  = vsync_i & ~vsync_prev;

  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    rd_o             = 1'b0;
    addr_rd_o        = ptr;
    frame_misalign_o = 1'b0;
    if (!page_written_once_i) begin
      state_next = WAIT_PAGE;
    end else begin
      unique case (state)
        WAIT_PAGE:  state_next = WAIT_VSYNC;
        WAIT_VSYNC: begin
          if (vsync_rise) begin
            state_next = ACTIVE;
            ptr_next   = '0;
          end
        end
        ACTIVE: begin
          // A frame start forces address 0 even if a read lands on the same cycle.
          if (vsync_rise) begin
            frame_misalign_o = (ptr != '0);
            addr_rd_o        = '0;
            ptr_next         = '0;
          end
          if (de_i) begin
            rd_o     = 1'b1;
            ptr_next = (addr_rd_o == total_pixel) ? '0 : addr_rd_o + ADDR_WIDTH'(1);
          end
        end
        default: state_next = WAIT_PAGE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= WAIT_PAGE;
      ptr        <= '0;
      vsync_prev <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      vsync_prev <= vsync_i;
    end
  end

  assign dly_in = {hsync_i, vsync_i, de_i, rd_o};

  sync_delay_line #(
    .WIDTH (4),
    .DEPTH (LAT)
  ) u_timing_delay (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (dly_in),
    .data_o  (dly_out)
  );

  assign {hsync_o, vsync_o, de_o, pixel_valid} = dly_out;
  assign pixel_o = pixel_valid ? rd_data_i : BLANK_PIXEL;

endmodule

// File: doc/frame_buffer_read_ctrl.md
FRAME_BUFFER_READ_CTRL -- requirements
Module: frame_buffer_read_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: frame-buffer address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: pixel width (RGB565).
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal 1..3: frame-buffer read latency in cycles.
REQ-004 SHALL have parameter BLANK_PIXEL, default 0: pixel value driven outside valid reads.
REQ-005 SHALL have ports:
- clk_i  in  1  pixel clock, single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- resolution_width_i  in  16  active pixels per line.
- resolution_depth_i  in  16  active lines per frame.
- page_written_once_i  in  1  writer has completed at least one full frame.
- hsync_i  in  1  HDMI timing hsync.
- vsync_i  in  1  HDMI timing vsync, active-high.
- de_i  in  1  HDMI timing display enable.
- rd_data_i  in  DATA_WIDTH  frame-buffer read data, valid RD_LATENCY cycles after rd_o.
- rd_o  out  1  frame-buffer read strobe.
- addr_rd_o  out  ADDR_WIDTH  frame-buffer read address.
- hsync_o  out  1  hsync_i delayed RD_LATENCY cycles.
- vsync_o  out  1  vsync_i delayed RD_LATENCY cycles.
- de_o  out  1  de_i delayed RD_LATENCY cycles.
- pixel_o  out  DATA_WIDTH  pixel aligned with de_o.
- frame_misalign_o  out  1  one-cycle pulse when the pointer was not at 0 on a frame start.

Function
REQ-006 SHALL compute total_pixel = width*depth - 1 at ADDR_WIDTH bits and use it as the last read address.
REQ-007 SHALL implement FSM states WAIT_PAGE, WAIT_VSYNC and ACTIVE.
REQ-008 SHALL move WAIT_PAGE -> WAIT_VSYNC on the first cycle page_written_once_i=1.
REQ-009 SHALL detect a vsync rising edge as vsync_i=1 with the registered previous vsync_i=0.
REQ-010 SHALL move WAIT_VSYNC -> ACTIVE on a vsync rising edge and clear the read pointer to 0.
REQ-011 SHALL return any state -> WAIT_PAGE when page_written_once_i=0, with rd_o=0 in that same cycle.
REQ-012 SHALL assert rd_o combinationally as (state==ACTIVE && de_i); rd_o SHALL be 0 in every other state.
REQ-013 SHALL drive addr_rd_o combinationally from the read pointer.
REQ-014 SHALL advance the pointer by 1 on each rd_o cycle and wrap total_pixel -> 0.
REQ-015 SHALL, on a vsync rising edge in ACTIVE:
- clear the pointer to 0;
- pulse frame_misalign_o for one cycle if the pointer was not 0.
REQ-016 SHALL, when a vsync rising edge and de_i=1 occur in the same cycle in ACTIVE, read address 0 in that cycle and set the pointer to 1.
REQ-017 SHALL delay hsync, vsync, de and rd_o through a RD_LATENCY-deep shift register; the delayed rd_o is pixel_valid.
REQ-018 SHALL drive pixel_o = rd_data_i when pixel_valid=1, else BLANK_PIXEL.
REQ-019 SHALL let de_o=1 with pixel_valid=0 (WAIT states) output BLANK_PIXEL, i.e. a black screen.

Reset
REQ-020 SHALL, on reset_i=1 at a clk_i edge, set state=WAIT_PAGE, pointer=0, previous vsync=0, and clear all delay stages.
REQ-021 SHALL, after reset, hold rd_o=0, addr_rd_o=0, hsync_o=vsync_o=de_o=0, pixel_o=BLANK_PIXEL, frame_misalign_o=0.
REQ-022 SHALL abort any frame in progress when reset asserts mid-frame, and SHALL wait for a new vsync edge after reset before reading.

Structure
REQ-023 SHALL place the FSM state encoding and the RD_LATENCY legal range in a shared frame-buffer package, also used by the write controller.
REQ-024 SHALL implement the delay line as one sub-module, sync_delay_line, parameterised by width and depth.

Verification
REQ-025 SHALL cover: width=4, depth=2, page_written_once_i=0, de toggling -> rd_o=0 always, pixel_o=0.
REQ-026 SHALL cover: page set, vsync edge, then 8 de cycles -> addr_rd_o 0..7; the 9th de cycle reads address 0 (wrap).
REQ-027 SHALL cover: RD_LATENCY=2, rd_data_i=addr+0x100 -> pixel_o=0x100.. aligned exactly with de_o, 2 cycles after rd_o.
REQ-028 SHALL cover: vsync edge after only 5 reads -> frame_misalign_o pulses once, next read at address 0.
REQ-029 SHALL cover: vsync edge coincident with de_i=1 -> address 0 read that cycle, next read at address 1.
REQ-030 SHALL cover: reset_i pulsed mid-frame at pointer=3 -> outputs take REQ-021 values, and reads resume at address 0 only after the next vsync edge.
